// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered ready, flush and saturating stall counter
module pipe_skid_stage #(
  parameter int DATAW = 64,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [DATAW-1:0] main_q, skid_q;
  logic acc, take;
  assign acc = in_valid & in_ready;
  assign take = out_valid & out_ready;
  assign out_data = main_q;
  // occupancy FSM; handshake outputs are registered alongside the state so in_ready never sees out_ready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else if (flush) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q <= in_data;
          state <= ONE;
          out_valid <= 1'b1;
          occupancy <= 2'd1;
        end
        ONE: if (acc && take) begin
          main_q <= in_data;
        end else if (acc) begin
          skid_q <= in_data;
          state <= FULL;
          in_ready <= 1'b0;
          occupancy <= 2'd2;
        end else if (take) begin
          main_q <= '0;
          state <= EMPTY;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
        FULL: if (take) begin
          main_q <= skid_q;
          skid_q <= '0;
          state <= ONE;
          in_ready <= 1'b1;
          occupancy <= 2'd1;
        end
        default: begin
          main_q <= '0;
          skid_q <= '0;
          state <= EMPTY;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  // stall counter: clear wins, otherwise count blocked cycles up to all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else stall_cnt <= cnt_clr ? '0 : (out_valid && !out_ready && !(&stall_cnt)) ? stall_cnt + CNTW'(1) : stall_cnt;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of pipe_skid_stage against a queue model
module tb_pipe_skid_stage;
  localparam int DATAW = 64;
  localparam int CNTW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DATAW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DATAW-1:0] out_data;
  logic [1:0] occupancy;
  logic [CNTW-1:0] stall_cnt;
  int checks = 0;
  int errors = 0;
  logic [DATAW-1:0] q[$];
  int mcnt = 0;
  pipe_skid_stage #(.DATAW(DATAW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // model: FIFO of at most two entries; ready iff fewer than two held
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      int n;
      n = q.size();
      if (cnt_clr) mcnt = 0;
      else if (n > 0 && !out_ready && mcnt < (1 << CNTW) - 1) mcnt++;
      if (flush) q.delete();
      else begin
        if (n > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) q.push_back(in_data);
      end
    end
  always @(negedge clk) begin
    check("m_occupancy", DATAW'(occupancy), DATAW'(q.size()));
    check("m_out_valid", DATAW'(out_valid), DATAW'(q.size() > 0));
    check("m_in_ready", DATAW'(in_ready), DATAW'(q.size() < 2));
    check("m_out_data", out_data, q.size() > 0 ? q[0] : '0);
    check("m_stall_cnt", DATAW'(stall_cnt), DATAW'(mcnt));
  end
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", DATAW'(out_valid), 0);
    check("rst_in_ready", DATAW'(in_ready), 1);
    check("rst_occupancy", DATAW'(occupancy), 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", DATAW'(stall_cnt), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1;
      in_data = DATAW'(i);
      step();
      check("stream_data", out_data, DATAW'(i));
      check("stream_occ", DATAW'(occupancy), 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", DATAW'(occupancy), 0);
    check("stream_stall", DATAW'(stall_cnt), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 'hA;
    step();
    in_data = 'hB;
    step();
    in_valid = 1'b0;
    check("bp_occ", DATAW'(occupancy), 2);
    check("bp_in_ready", DATAW'(in_ready), 0);
    check("bp_data", out_data, 'hA);
    check("bp_stall1", DATAW'(stall_cnt), 1);
    step();
    check("bp_stall2", DATAW'(stall_cnt), 2);
    out_ready = 1'b1;
    step();
    check("bp_data_b", out_data, 'hB);
    check("bp_ready_back", DATAW'(in_ready), 1);
    step();
    check("bp_empty", DATAW'(out_valid), 0);
    check("bp_empty_data", out_data, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 'hA;
    step();
    in_data = 'hB;
    step();
    flush = 1'b1;
    in_data = 'hC;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_occ", DATAW'(occupancy), 0);
    check("fl_valid", DATAW'(out_valid), 0);
    check("fl_data", out_data, 0);
    check("fl_ready", DATAW'(in_ready), 1);
    check("fl_stall_kept", DATAW'(stall_cnt), 4);
    out_ready = 1'b1;
    step();
    step();
    check("fl_no_c", DATAW'(out_valid), 0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("sat_clr0", DATAW'(stall_cnt), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 'hA;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("sat_15", DATAW'(stall_cnt), 15);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("sat_clr", DATAW'(stall_cnt), 0);
    step();
    check("sat_resume", DATAW'(stall_cnt), 1);
    in_valid = 1'b1;
    in_data = 'hB;
    step();
    in_valid = 1'b0;
    check("ar_full", DATAW'(occupancy), 2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", DATAW'(out_valid), 0);
    check("ar_occ", DATAW'(occupancy), 0);
    check("ar_data", out_data, 0);
    check("ar_ready", DATAW'(in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_data = 'h5;
    step();
    in_valid = 1'b0;
    check("ar_push5", out_data, 'h5);
    check("ar_push5_valid", DATAW'(out_valid), 1);
    for (int i = 0; i < 10000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 63) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
